// File: rtl/reg_file_2r1w.sv
// 32 x 32 general-purpose register file: two combinational read ports and one
// rising-edge write port. r0 reads as zero, and the write port bypasses to the reads.
module reg_file_2r1w #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [ADDR_WIDTH-1:0] ra1,
  input  logic [ADDR_WIDTH-1:0] ra2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // r0 has no storage; entries start at index 1.
  logic [DATA_WIDTH-1:0] regs [1:DEPTH-1];
  logic                  wr_hit;

  // A write is live only out of reset and to a non-zero address.
  assign wr_hit = we & rst_n & (|wa);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_hit) begin
      regs[wa] <= wd;
    end
  end

  // Reset drives both outputs to zero. Otherwise a matching write bypasses to the
  // read port, and a read of r0 returns zero.
  always_comb begin
    rd1 = '0;
    if (wr_hit && (wa == ra1)) begin
      rd1 = wd;
    end else if (rst_n && (|ra1)) begin
      rd1 = regs[ra1];
    end
  end

  always_comb begin
    rd2 = '0;
    if (wr_hit && (wa == ra2)) begin
      rd2 = wd;
    end else if (rst_n && (|ra2)) begin
      rd2 = regs[ra2];
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w: a vector table plus hand-written sequences for
// full write/readback, asynchronous reset, and bypass collisions.
module tb_reg_file_2r1w;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;

  int n_cmp;
  int n_bad;

  reg_file_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .wa    (wa),
    .wd    (wd),
    .ra1   (ra1),
    .ra2   (ra2),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        do_edge;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // The bench drives inputs at the falling edge and checks them 1 ns later.
  // It then waits for the rising edge when the step asks for a commit.
  task automatic step(input string nm, input logic w, input logic [4:0] a, input logic [31:0] d,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic [31:0] e1, input logic [31:0] e2, input logic do_edge);
    @(negedge clk);
    we = w; wa = a; wd = d; ra1 = r1; ra2 = r2;
    #1;
    check({nm, ".rd1"}, rd1, e1);
    check({nm, ".rd2"}, rd2, e2);
    if (do_edge) @(posedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    we = 1'b0; wa = '0; wd = '0; ra1 = 5'd5; ra2 = 5'd31;

    // Reset state.
    #2;
    check("reset.rd1", rd1, 32'h0);
    check("reset.rd2", rd2, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1};
    vecs[1]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 32'h0, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 5'd1, 32'hFEEDFEED, 5'd1, 5'd2, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1};
    vecs[4]  = '{1'b0, 5'd1, 32'hFEEDFEED, 5'd1, 5'd2, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1};
    vecs[5]  = '{1'b0, 5'd1, 32'hFEEDFEED, 5'd1, 5'd2, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1};
    vecs[6]  = '{1'b0, 5'd1, 32'hFEEDFEED, 5'd0, 5'd2, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[7]  = '{1'b0, 5'd1, 32'hFEEDFEED, 5'd1, 5'd2, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vecs[8]  = '{1'b1, 5'd3, 32'hAAAA5555, 5'd3, 5'd4, 32'hAAAA5555, 32'hDEADBEEF, 1'b1};
    vecs[9]  = '{1'b1, 5'd3, 32'h0F0F0F0F, 5'd3, 5'd3, 32'h0F0F0F0F, 32'h0F0F0F0F, 1'b1};
    vecs[10] = '{1'b0, 5'd3, 32'h0,        5'd3, 5'd3, 32'h0F0F0F0F, 32'h0F0F0F0F, 1'b0};
    vecs[11] = '{1'b1, 5'd3, 32'h12121212, 5'd3, 5'd4, 32'h12121212, 32'hDEADBEEF, 1'b1};
    vecs[12] = '{1'b0, 5'd3, 32'h0,        5'd3, 5'd4, 32'h12121212, 32'hDEADBEEF, 1'b0};
    vecs[13] = '{1'b1, 5'd9, 32'h99999999, 5'd8, 5'd9, 32'hDEADBEEF, 32'h99999999, 1'b1};

    // r0 write attempts.
    for (int v = 0; v < 3; v++) begin
      step($sformatf("vec%0d", v), vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra1,
           vecs[v].ra2, vecs[v].e1, vecs[v].e2, vecs[v].do_edge);
    end

    // Write every register: check the bypass before the edge and the stored value after it.
    for (int i = 1; i < 32; i++) begin
      step($sformatf("wr%0d", i), 1'b1, 5'(i), 32'hDEADBEEF, 5'(i), 5'(i - 1),
           32'hDEADBEEF, (i > 1) ? 32'hDEADBEEF : 32'h0, 1'b1);
      step($sformatf("rb%0d", i), 1'b0, 5'(i), 32'h0, 5'(i), 5'd0,
           32'hDEADBEEF, 32'h0, 1'b0);
    end

    // Write-enable gating, asynchronous read, and collisions.
    for (int v = 3; v < 14; v++) begin
      step($sformatf("vec%0d", v), vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra1,
           vecs[v].ra2, vecs[v].e1, vecs[v].e2, vecs[v].do_edge);
    end

    // Load distinct values, then assert reset between clock edges.
    for (int i = 1; i < 32; i++) begin
      step($sformatf("ld%0d", i), 1'b1, 5'(i), 32'(i) * 32'h01010101, 5'(i), 5'd0,
           32'(i) * 32'h01010101, 32'h0, 1'b1);
    end
    step("preRst", 1'b0, 5'd0, 32'h0, 5'd7, 5'd30, 32'h07070707, 32'h1E1E1E1E, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("asyncRst.rd1", rd1, 32'h0);
    check("asyncRst.rd2", rd2, 32'h0);

    // The write is attempted during reset; the bypass must also stay quiet.
    we = 1'b1; wa = 5'd5; wd = 32'h12345678; ra1 = 5'd5; ra2 = 5'd5;
    #1;
    check("rstBypass.rd1", rd1, 32'h0);
    check("rstBypass.rd2", rd2, 32'h0);
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rstNoWrite.r5", rd1, 32'h0);
    ra1 = 5'd7; ra2 = 5'd31;
    #1;
    check("rstCleared.r7", rd1, 32'h0);
    check("rstCleared.r31", rd2, 32'h0);
    step("postRstWr", 1'b1, 5'd5, 32'h12345678, 5'd5, 5'd6, 32'h12345678, 32'h0, 1'b1);
    step("postRstRb", 1'b0, 5'd0, 32'h0, 5'd5, 5'd4, 32'h12345678, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- 32-entry x 32-bit general-purpose register file for the MIPS150 datapath.
- Two asynchronous read ports feed the decode/operand stage; one synchronous write port is driven by writeback.
- Register 0 is hardwired to zero.
- A same-cycle write-through bypass lets a value being written be read back in the cycle it is presented.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH (32 entries).

Ports:
- clk  input  1  system clock; all writes occur on the rising edge.
- rst_n  input  1  asynchronous active-low reset; clears all registers.
- we  input  1  write enable for the write port.
- wa  input  ADDR_WIDTH  write address.
- wd  input  DATA_WIDTH  write data.
- ra1  input  ADDR_WIDTH  read address, port 1.
- ra2  input  ADDR_WIDTH  read address, port 2.
- rd1  output  DATA_WIDTH  read data, port 1 (combinational).
- rd2  output  DATA_WIDTH  read data, port 2 (combinational).

Behaviour:
- Storage: registers 1..31 are flops; register 0 has no storage and always reads 0.
- Reset:
  - rst_n low immediately (asynchronously) clears registers 1..31 to 0, independent of clk.
  - While rst_n is low, writes are ignored.
  - rd1/rd2 are pure functions of state and inputs, so they read 0 for every address during reset, bypass included.
  - Deassertion takes effect at the next rising edge; no write occurs on an edge where rst_n is low.
- Write:
  - On the rising clk edge with rst_n high, we=1 and wa!=0: reg[wa] <= wd.
  - we=0: no register changes, whatever wa/wd are.
  - wa=0 with we=1: no-op; register 0 stays 0.
- Read:
  - rd1 and rd2 are fully combinational (zero-cycle latency); they respond to ra1/ra2 changes within the same delta, with no clock needed.
  - The two ports are independent, and both may address the same register.
- Bypass (per port, shown for port 1):
  - If we=1, wa!=0, wa==ra1 and rst_n=1: rd1 = wd.
  - Else if ra1==0: rd1 = 0.
  - Else: rd1 = reg[ra1].
  - Port 2 is identical with ra2/rd2.
  - The bypass is combinational, so a write's data is visible on the read port in the same cycle it is presented, before the clock edge commits it.
  - After the edge the stored value matches wd, so the output is unchanged across the edge.
- Simultaneous events:
  - Reset asserted at a write edge: reset wins.
  - Reads and writes to the same address in the same cycle return the new (bypassed) data.
  - Both read ports addressing the write target both receive wd.
- No X propagation from address inputs is required beyond the standard simulator behaviour; all 32 address values are legal.

Test Plan:
- Write to r0: rst_n=1, we=1, wa=0, wd=32'hFFFFFFFF, ra1=ra2=0, apply clock edges -> rd1=rd2=32'h0 before and after the edges.
- Write/readback all registers: we=1, wd=32'hDEADBEEF, for wa=1..31 set ra1=wa -> rd1=32'hDEADBEEF immediately (bypass) and after the rising edge (stored); rd2 on a previously written register also reads 32'hDEADBEEF.
- Write enable gating: after the above, we=0, wa=1, wd=32'hFEEDFEED, ra1=1, several clock edges -> rd1 stays 32'hDEADBEEF.
- Asynchronous read: with no clock edge, switch ra1 1->0->1 -> rd1 goes DEADBEEF -> 0 -> DEADBEEF combinationally; rd2 is unaffected by ra1.
- Asynchronous reset: registers loaded with distinct values (reg[i]=i*32'h01010101), pull rst_n low mid-cycle (no clk edge) -> all rd1/rd2 reads return 0 immediately; with rst_n low, a write attempt (we=1, wa=5, wd=32'h12345678) at an edge leaves reg 5 = 0; after rst_n high, the write succeeds.
- Dual-port/bypass collision: reg[3]=32'hAAAA5555, then we=1, wa=3, wd=32'h0F0F0F0F, ra1=3, ra2=3 -> both ports read 32'h0F0F0F0F before the edge; after the edge with we=0, both still read 32'h0F0F0F0F; ra2=4 concurrently shows reg[4] unchanged.
